// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the core (requester 0) and the loader (requester 1), one transaction at a time
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   c_*_i / l_*_i               request level, we, size, byte address, store data per requester
//   c_gnt_o / l_gnt_o           one-cycle grant pulse in the ISSUE cycle
//   c_rvalid_o / l_rvalid_o     one-cycle completion pulse in the RESP cycle
//   c_rdata_o / l_rdata_o       read data, held until the next read completion to that requester
//   mem_addr_o/mem_ctrl_o/mem_wdata_o  registered request toward memory
//   mem_we_o                    write strobe, ISSUE cycle only
//   mem_rdata_i                 memory read data, valid MEM_LAT cycles after ISSUE
//   busy_o                      high whenever a transaction is in flight
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [1:0]        c_ctrl_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [1:0]        l_ctrl_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [DATA_W-1:0] c_rdata_o,
  output logic              l_gnt_o,
  output logic              l_rvalid_o,
  output logic [DATA_W-1:0] l_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_ctrl_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              last_q;
  logic              we_q;
  logic [1:0]        ctrl_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] l_rdata_q;
  logic              win;
  logic              arb;
  logic [1:0]        ctrl_sel;
  // last_q doubles as the owner of the transaction in flight, since it is updated to every winner
  assign win      = (c_req_i & l_req_i) ? ~last_q : l_req_i;
  assign arb      = (state_q == IDLE || state_q == RESP) && (c_req_i | l_req_i);
  assign ctrl_sel = win ? l_ctrl_i : c_ctrl_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = arb ? ISSUE : IDLE;
      ISSUE:      state_d = WAIT;
      WAIT:       state_d = (cnt_q == 4'd0) ? RESP : WAIT;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    c_gnt_o    = state_q == ISSUE && !last_q;
    l_gnt_o    = state_q == ISSUE &&  last_q;
    c_rvalid_o = state_q == RESP  && !last_q;
    l_rvalid_o = state_q == RESP  &&  last_q;
    mem_we_o   = state_q == ISSUE && we_q;
    busy_o     = state_q != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      ctrl_q    <= 2'd0;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (arb) begin
        last_q  <= win;
        we_q    <= win ? l_we_i : c_we_i;
        ctrl_q  <= (ctrl_sel == 2'd3) ? 2'd2 : ctrl_sel;
        addr_q  <= win ? l_addr_i : c_addr_i;
        wdata_q <= win ? l_wdata_i : c_wdata_i;
      end
      if (state_q == ISSUE) cnt_q <= 4'(MEM_LAT - 1);
      else if (state_q == WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (state_q == WAIT && cnt_q == 4'd0 && !we_q) begin
        if (last_q) l_rdata_q <= mem_rdata_i;
        else        c_rdata_q <= mem_rdata_i;
      end
    end
  end
  assign mem_addr_o  = addr_q;
  assign mem_ctrl_o  = ctrl_q;
  assign mem_wdata_o = wdata_q;
  assign c_rdata_o   = c_rdata_q;
  assign l_rdata_o   = l_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks mem_arbiter at MEM_LAT 1, 2 and 15 against a transaction-level model
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        c_req, c_we, l_req, l_we;
  logic [1:0]  c_ctrl, l_ctrl;
  logic [31:0] c_addr, l_addr, c_wdata, l_wdata, mem_rdata;
  logic        c_gnt [3], l_gnt [3], c_rv [3], l_rv [3], mwe [3], bsy [3];
  logic [31:0] c_rd [3], l_rd [3], maddr [3], mwd [3];
  logic [1:0]  mctrl [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : (g == 1 ? 2 : 15))) u_dut (
      .clk(clk), .rst(rst),
      .c_req_i(c_req), .c_we_i(c_we), .c_ctrl_i(c_ctrl), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
      .l_req_i(l_req), .l_we_i(l_we), .l_ctrl_i(l_ctrl), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
      .c_gnt_o(c_gnt[g]), .c_rvalid_o(c_rv[g]), .c_rdata_o(c_rd[g]),
      .l_gnt_o(l_gnt[g]), .l_rvalid_o(l_rv[g]), .l_rdata_o(l_rd[g]),
      .mem_addr_o(maddr[g]), .mem_we_o(mwe[g]), .mem_ctrl_o(mctrl[g]), .mem_wdata_o(mwd[g]),
      .mem_rdata_i(mem_rdata), .busy_o(bsy[g]));
  end
  int sel = 0;
  int lat = 1;
  int checks = 0;
  int errors = 0;
  int last_m = 1;
  logic [31:0] exp_rd [2];
  logic [5:0]  st;
  logic [31:0] o_maddr, o_mwd, o_crd, o_lrd;
  logic [1:0]  o_mctrl;
  assign st      = {c_gnt[sel], l_gnt[sel], c_rv[sel], l_rv[sel], mwe[sel], bsy[sel]};
  assign o_maddr = maddr[sel];
  assign o_mwd   = mwd[sel];
  assign o_mctrl = mctrl[sel];
  assign o_crd   = c_rd[sel];
  assign o_lrd   = l_rd[sel];
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : (a == 32'h40 ? 32'h12345678 : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lat=%0d observed=%h expected=%h", tag, lat, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 32'(st), 32'h0);
    chk({tag, "_addr"}, o_maddr, 32'h0);
    chk({tag, "_ctrl"}, 32'(o_mctrl), 32'h0);
    chk({tag, "_wdata"}, o_mwd, 32'h0);
    chk({tag, "_crdata"}, o_crd, 32'h0);
    chk({tag, "_lrdata"}, o_lrd, 32'h0);
  endtask
  task automatic new_fields(input int k);
    if (k == 0) begin
      c_req = $urandom_range(0, 3) != 0; c_we = 1'($urandom); c_ctrl = 2'($urandom);
      c_addr = $urandom; c_wdata = $urandom;
    end else begin
      l_req = $urandom_range(0, 3) != 0; l_we = 1'($urandom); l_ctrl = 2'($urandom);
      l_addr = $urandom; l_wdata = $urandom;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_zero("reset");
    step();
    c_req = 1'b0; l_req = 1'b0; rst = 1'b0;
    last_m = 1; exp_rd[0] = '0; exp_rd[1] = '0;
  endtask
  // Called in the cycle before an arbitration edge; runs one arbitration and, if won, the whole transaction.
  // mode 0: winner drops req at gnt; 1: random new requests; 2: winner keeps requesting with new fields.
  task automatic txn(input int mode, input bit tog);
    int w;
    bit both, we, cr, lr;
    logic [1:0] ct;
    logic [31:0] a, d;
    if (!c_req && !l_req) begin
      step();
      chk("idle", 32'(st), 32'h0);
      new_fields(0); new_fields(1);
      return;
    end
    both = c_req && l_req;
    w = both ? 1 - last_m : (l_req ? 1 : 0);
    we = w == 1 ? l_we : c_we;
    ct = w == 1 ? l_ctrl : c_ctrl;
    a = w == 1 ? l_addr : c_addr;
    d = w == 1 ? l_wdata : c_wdata;
    last_m = w;
    step();
    chk("issue_flags", 32'(st), 32'({w == 0, w == 1, 2'b00, we, 1'b1}));
    chk("issue_addr", o_maddr, a);
    chk("issue_ctrl", 32'(o_mctrl), ct == 2'd3 ? 32'd2 : 32'(ct));
    chk("issue_wdata", o_mwd, d);
    mem_rdata = $urandom;
    if (mode == 1) begin
      new_fields(w);
      if (!both) new_fields(1 - w);
    end else if (mode == 2) begin
      if (w == 1) begin l_addr = $urandom; l_wdata = $urandom; end
      else begin c_addr = $urandom; c_wdata = $urandom; end
    end else if (w == 1) l_req = 1'b0;
    else c_req = 1'b0;
    cr = c_req; lr = l_req;
    for (int i = 1; i <= lat; i++) begin
      step();
      chk("wait_flags", 32'(st), 32'h1);
      chk("wait_addr", o_maddr, a);
      mem_rdata = i == lat ? mem_f(a) : $urandom;
      if (tog) begin c_req = 1'($urandom); l_req = 1'($urandom); end
    end
    c_req = cr; l_req = lr;
    step();
    if (!we) exp_rd[w] = mem_f(a);
    chk("resp_flags", 32'(st), 32'({2'b00, w == 0, w == 1, 2'b01}));
    chk("resp_addr", o_maddr, a);
    chk("resp_crdata", o_crd, exp_rd[0]);
    chk("resp_lrdata", o_lrd, exp_rd[1]);
    mem_rdata = $urandom;
  endtask
  initial begin
    c_req = 0; c_we = 0; c_ctrl = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_ctrl = 0; l_addr = 0; l_wdata = 0;
    mem_rdata = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    step();
    step();
    chk_zero("por");
    rst = 1'b0;
    // MEM_LAT = 1
    c_req = 1; c_we = 0; c_ctrl = 2; c_addr = 32'h100;
    txn(0, 0);
    l_req = 1; l_we = 1; l_ctrl = 0; l_addr = 32'h3; l_wdata = 32'hA5;
    txn(0, 0);
    c_req = 1; c_we = 0; c_ctrl = 3; c_addr = 32'h44;
    txn(0, 0);
    c_req = 1; c_we = 0; c_ctrl = 2; c_addr = 32'h200;
    step();
    chk("rst_pre_gnt", 32'(st), 32'b100001);
    c_req = 0;
    step();
    chk("rst_pre_wait", 32'(st), 32'h1);
    do_reset();
    repeat (3) begin
      step();
      chk("post_rst_idle", 32'(st), 32'h0);
    end
    c_req = 1; l_req = 1; c_we = 0; l_we = 0; c_addr = 32'h300; l_addr = 32'h304;
    txn(0, 0);
    new_fields(0); new_fields(1);
    repeat (30) txn(1, 1);
    // MEM_LAT = 2: strict alternation under continuous dual requests
    sel = 1; lat = 2;
    do_reset();
    c_req = 1; c_we = 0; c_ctrl = 2; c_addr = 32'h10;
    l_req = 1; l_we = 0; l_ctrl = 1; l_addr = 32'h20;
    repeat (4) txn(2, 0);
    new_fields(0); new_fields(1);
    repeat (30) txn(1, 1);
    // MEM_LAT = 15
    sel = 2; lat = 15;
    do_reset();
    c_req = 1; c_we = 0; c_ctrl = 2; c_addr = 32'h40;
    txn(0, 1);
    new_fields(0); new_fields(1);
    repeat (8) txn(1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
